// File: rtl/des_sbox_engine_if.sv
// Stream interface for des_sbox_engine: input vector handshake and result handshake.
interface des_sbox_engine_if #(
  parameter int unsigned NUM_BOX = 8,
  parameter int unsigned IN_W    = 6,
  parameter int unsigned OUT_W   = 4
);
  logic                       i_valid;
  logic                       o_ready;
  logic [NUM_BOX*IN_W-1:0]    i_vector;
  logic                       o_valid;
  logic                       i_ready;
  logic [NUM_BOX*OUT_W-1:0]   o_vector;

  modport master (
    output i_valid, i_vector, i_ready,
    input  o_ready, o_valid, o_vector
  );

  modport slave (
    input  i_valid, i_vector, i_ready,
    output o_ready, o_valid, o_vector
  );
endinterface

// File: rtl/des_sbox_engine.sv
// Programmable, time-multiplexed DES S-box engine: NUM_BOX loadable tables, LANES lookups per cycle.
// Optional macro SBOX_PARITY_EN adds per-entry even parity and a sticky o_parity_err output.
module des_sbox_engine #(
  parameter int unsigned NUM_BOX = 8,
  parameter int unsigned IN_W    = 6,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned LANES   = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cfg_we,
  input  logic [$clog2(NUM_BOX)-1:0] i_cfg_box,
  input  logic [IN_W-1:0]            i_cfg_addr,
  input  logic [OUT_W-1:0]           i_cfg_data,
  output logic                       o_cfg_drop,
  des_sbox_engine_if.slave           bus,
  output logic                       o_busy
`ifdef SBOX_PARITY_EN
  ,
  output logic                       o_parity_err
`endif
);

  localparam int unsigned BOX_W  = $clog2(NUM_BOX);
  localparam int unsigned DEPTH  = 2 ** IN_W;
  localparam int unsigned VIN_W  = NUM_BOX * IN_W;
  localparam int unsigned VOUT_W = NUM_BOX * OUT_W;
`ifdef SBOX_PARITY_EN
  localparam int unsigned ENT_W  = OUT_W + 1;
`else
  localparam int unsigned ENT_W  = OUT_W;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [BOX_W-1:0]    cnt_q, cnt_d;
  logic [VIN_W-1:0]    vec_q, vec_d;
  logic [VOUT_W-1:0]   res_q, res_d;
  logic                drop_q, drop_d;
  logic [ENT_W-1:0]    tbl_q [NUM_BOX][DEPTH];

  logic                cfg_box_ok;
  logic                cfg_wr;
  logic [ENT_W-1:0]    cfg_ent;
  logic [BOX_W-1:0]    lane_box [LANES];
  logic [ENT_W-1:0]    lane_ent [LANES];

  assign cfg_box_ok = (32'(i_cfg_box) < NUM_BOX);
  assign cfg_wr     = i_cfg_we && (state_q == IDLE) && cfg_box_ok;
  assign drop_d     = i_cfg_we && ((state_q != IDLE) || !cfg_box_ok);

`ifdef SBOX_PARITY_EN
  assign cfg_ent = {^i_cfg_data, i_cfg_data};
`else
  assign cfg_ent = i_cfg_data;
`endif

  // Box indices served by each lane this cycle
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_box[l] = cnt_q + BOX_W'(l);
    end
  end

  // Raw IN_W-bit chunk is the table index; box 0 sits in the MSB chunk
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_ent[l] = tbl_q[lane_box[l]][vec_q[(NUM_BOX - 32'(lane_box[l])) * IN_W - 1 -: IN_W]];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          vec_d   = bus.i_vector;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          res_d[(NUM_BOX - 32'(lane_box[l])) * OUT_W - 1 -: OUT_W] = lane_ent[l][OUT_W-1:0];
        end
        cnt_d = cnt_q + BOX_W'(LANES);
        if (32'(cnt_q) + LANES == NUM_BOX) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      res_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
      drop_q  <= drop_d;
    end
  end

  // Lookup tables; writes land only while idle so a running vector never sees a torn table
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NUM_BOX; b++) begin
        for (int a = 0; a < DEPTH; a++) begin
          tbl_q[b][a] <= '0;
        end
      end
    end else if (cfg_wr) begin
      tbl_q[i_cfg_box][i_cfg_addr] <= cfg_ent;
    end
  end

`ifdef SBOX_PARITY_EN
  logic               par_err_q, par_err_d;
  logic [LANES-1:0]   lane_bad;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_bad[l] = ^lane_ent[l];
    end
  end

  assign par_err_d = par_err_q || ((state_q == RUN) && (|lane_bad));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign o_parity_err = par_err_q;
`endif

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_vector = res_q;
  assign o_busy       = (state_q != IDLE);
  assign o_cfg_drop   = drop_q;

endmodule

// File: tb/tb_des_sbox_engine.sv
// Directed bench for des_sbox_engine: table loads, handshake timing, drops, reset abort.
// Define SBOX_PARITY_EN for both RTL and bench to exercise the parity checker.
module tb_des_sbox_engine;

  localparam int unsigned NUM_BOX = 8;
  localparam int unsigned IN_W    = 6;
  localparam int unsigned OUT_W   = 4;
  localparam int unsigned LANES   = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  cfg_we;
  logic [2:0]            cfg_box;
  logic [IN_W-1:0]       cfg_addr;
  logic [OUT_W-1:0]      cfg_data;
  logic                  cfg_drop;
  logic                  busy;
`ifdef SBOX_PARITY_EN
  logic                  parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  des_sbox_engine_if #(.NUM_BOX(NUM_BOX), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  des_sbox_engine #(
    .NUM_BOX(NUM_BOX), .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cfg_we    (cfg_we),
    .i_cfg_box   (cfg_box),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_data  (cfg_data),
    .o_cfg_drop  (cfg_drop),
    .bus         (bus),
    .o_busy      (busy)
`ifdef SBOX_PARITY_EN
    ,
    .o_parity_err(parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge
  task automatic cfg_write(input int box, input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_box  = 3'(box);
    cfg_addr = 6'(addr);
    cfg_data = 4'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic start_vec(input logic [47:0] vec);
    int n = 0;
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'(bus.o_ready), 64'd1);
    bus.i_valid  = 1'b1;
    bus.i_vector = vec;
    @(negedge clk);
    bus.i_valid  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int lat, input logic [31:0] exp);
    int n = 0;
    while (!bus.o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_vector"}, 64'(bus.o_vector), 64'(exp));
  endtask

  task automatic transact(input string tag, input logic [47:0] vec, input logic [31:0] exp);
    start_vec(vec);
    wait_result(tag, 4, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [47:0] ramp;
    logic [31:0] held;

    rst_n        = 1'b0;
    cfg_we       = 1'b0;
    cfg_box      = '0;
    cfg_addr     = '0;
    cfg_data     = '0;
    bus.i_valid  = 1'b0;
    bus.i_vector = '0;
    bus.i_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ready",  64'(bus.o_ready),  64'd1);
    chk("rst_valid",  64'(bus.o_valid),  64'd0);
    chk("rst_busy",   64'(busy),         64'd0);
    chk("rst_drop",   64'(cfg_drop),     64'd0);
    chk("rst_vector", 64'(bus.o_vector), 64'd0);
`ifdef SBOX_PARITY_EN
    chk("rst_parity", 64'(parity_err),   64'd0);
`endif

    // DES S1 row-ordered entries in box 0
    cfg_write(0, 0, 14);
    cfg_write(0, 1, 0);
    cfg_write(0, 2, 4);
    cfg_write(0, 63, 13);
    transact("s1_zero", 48'h000000000000, 32'hE0000000);
    transact("s1_fc",   48'hFC0000000000, 32'hD0000000);

    // box k, entry a = (a+k)&15
    for (int k = 0; k < 8; k++)
      for (int a = 0; a < 64; a++)
        cfg_write(k, a, (a + k) & 15);
    // chunk 63 in every box: (63+k)&15 = 15,0,1,...,6
    transact("ones", 48'hFFFFFFFFFFFF, 32'hF0123456);
    // box k sees chunk k: (k+k)&15 = 0,2,4,...,14
    ramp = '0;
    for (int k = 0; k < 8; k++) ramp[(8 - k) * 6 - 1 -: 6] = 6'(k);
    transact("ramp", ramp, 32'h02468ACE);

    // Back-pressure in DONE, with a new request already waiting
    bus.i_ready = 1'b0;
    start_vec(48'hFFFFFFFFFFFF);
    wait_result("hold", 4, 32'hF0123456);
    held         = bus.o_vector;
    bus.i_valid  = 1'b1;
    bus.i_vector = 48'h000000000000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_valid",  64'(bus.o_valid),  64'd1);
      chk("hold_ready",  64'(bus.o_ready),  64'd0);
      chk("hold_vector", 64'(bus.o_vector), 64'(held));
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", 64'(bus.o_ready), 64'd1);
    chk("release_busy",  64'(busy),        64'd0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("accept_busy",   64'(busy),        64'd1);
    // entry 0 of box k is k
    wait_result("after_hold", 4, 32'h01234567);
    @(negedge clk);

    // Write during RUN is dropped
    start_vec(48'h000000000000);
    cfg_write(0, 0, 5);
    chk("run_drop_pulse", 64'(cfg_drop), 64'd1);
    wait_result("run_drop", 3, 32'h01234567);
    chk("run_drop_clear", 64'(cfg_drop), 64'd0);
    @(negedge clk);
    transact("readback", 48'h000000000000, 32'h01234567);

    // Write on the same edge as the handshake is seen by that vector
    cfg_we       = 1'b1;
    cfg_box      = 3'd0;
    cfg_addr     = 6'd0;
    cfg_data     = 4'd9;
    bus.i_valid  = 1'b1;
    bus.i_vector = 48'h000000000000;
    @(negedge clk);
    cfg_we       = 1'b0;
    bus.i_valid  = 1'b0;
    chk("same_edge_drop", 64'(cfg_drop), 64'd0);
    wait_result("same_edge", 4, 32'h91234567);
    @(negedge clk);

    // Reset on the second RUN cycle aborts everything
    start_vec(48'hFFFFFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid",  64'(bus.o_valid),  64'd0);
    chk("abort_vector", 64'(bus.o_vector), 64'd0);
    chk("abort_busy",   64'(busy),         64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.o_ready), 64'd1);
    chk("post_rst_valid", 64'(bus.o_valid), 64'd0);
    cfg_write(3, 63, 7);
    transact("cleared_tables", 48'hFFFFFFFFFFFF, 32'h00070000);

`ifdef SBOX_PARITY_EN
    chk("parity_clean", 64'(parity_err), 64'd0);
    dut.tbl_q[1][1] = 5'b00001;
    transact("parity_bad", 48'h001000000000, 32'h01000000);
    chk("parity_set", 64'(parity_err), 64'd1);
    transact("parity_after", 48'h000000000000, 32'h00000000);
    chk("parity_sticky", 64'(parity_err), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
